// File: rtl/bcd_scan_mux_if.sv
// rtl/bcd_scan_mux_if.sv - load/control inputs and scanned display outputs of bcd_scan_mux
interface bcd_scan_mux_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] din;
  logic                din_vld;
  logic                disp_en;
  logic                blank_lead;
  logic [3:0]          bcd_out;
  logic [DIGITS-1:0]   digit_sel;
  logic                scan_tick;
  logic                err;

  modport master (
    output din, din_vld, disp_en, blank_lead,
    input  bcd_out, digit_sel, scan_tick, err
  );

  modport slave (
    input  din, din_vld, disp_en, blank_lead,
    output bcd_out, digit_sel, scan_tick, err
  );
endinterface

// File: rtl/bcd_scan_mux.sv
// rtl/bcd_scan_mux.sv - time-multiplexes a packed BCD value onto a 4-bit bus with active-low digit selects
module bcd_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  bcd_scan_mux_if.slave    bus
);
  localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic [4*DIGITS-1:0] shadow;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       div_cnt;

  logic [3:0]          bcd_q;
  logic [DIGITS-1:0]   sel_q;
  logic                tick_q;
  logic                err_q;

  logic                din_ok;
  logic                upper_zero;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          cur_nib;
  logic [DIGITS-1:0]   sel_nxt;
  logic                wrap;

  always_comb begin
    din_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (bus.din[4*k +: 4] > 4'd9) din_ok = 1'b0;
    end
  end

  // Walk down from the most significant digit; a digit is blank only while every digit above it is zero.
  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (shadow[4*k +: 4] == 4'd0);
      blank[k]   = bus.blank_lead & upper_zero;
    end
  end

  assign cur_nib = shadow[4*int'(idx) +: 4];
  assign wrap    = (div_cnt == DIV_LAST);

  always_comb begin
    sel_nxt = '1;
    if (bus.disp_en && !blank[idx]) sel_nxt[idx] = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shadow  <= '0;
      idx     <= '0;
      div_cnt <= '0;
      bcd_q   <= '0;
      sel_q   <= '1;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (bus.din_vld && din_ok) shadow <= bus.din;
      err_q <= bus.din_vld & ~din_ok;

      if (wrap) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      tick_q <= wrap;

      // Output stage samples pre-edge idx, so it trails the index by one cycle.
      bcd_q <= cur_nib;
      sel_q <= sel_nxt;
    end
  end

  assign bus.bcd_out   = bcd_q;
  assign bus.digit_sel = sel_q;
  assign bus.scan_tick = tick_q;
  assign bus.err       = err_q;
endmodule

// File: doc/bcd_scan_mux.md
Name: bcd_scan_mux

Overview:
- Upstream driver for the BCD-to-7-segment decoder in the display path.
- Holds a packed multi-digit BCD value and time-multiplexes it onto a shared 4-bit BCD bus, which feeds the decoder.
- Drives one active-low digit-select line per digit. Performs leading-zero blanking and rejects non-BCD input words.

Parameters:
- DIGITS, 4, number of digits scanned; legal range 2..8.
- SCAN_DIV, 50000, clock cycles per digit dwell (1 kHz per digit at 50 MHz); must be at least 2.

Ports:
- sys_clk  input  1  system clock; all state changes on its rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- din  input  4*DIGITS  packed BCD value; nibble k (bits 4k+3:4k) is digit k, and digit 0 is least significant.
- din_vld  input  1  single-cycle load strobe for din.
- disp_en  input  1  1 = display enabled; 0 = all digits dark while scanning continues.
- blank_lead  input  1  1 = leading-zero suppression enabled.
- bcd_out  output  4  BCD code of the currently scanned digit, going to the decoder.
- digit_sel  output  DIGITS  active-low digit enables; at most one bit is low.
- scan_tick  output  1  one-cycle pulse when the scan index advances.
- err  output  1  one-cycle pulse when a din_vld word is rejected.

Behaviour:
- Reset (asynchronous, while sys_rst_n=0):
  - Internal state: shadow=0, idx=0, div_cnt=0.
  - Outputs: bcd_out=0, digit_sel=all ones, scan_tick=0, err=0.
  - Reset applied mid-scan or mid-load discards everything; no partial load survives.
- Load:
  - At an edge with din_vld=1, every nibble is checked.
  - All nibbles <=9: shadow<=din and err<=0.
  - Any nibble >9: shadow is unchanged and err<=1 for exactly one cycle.
  - A valid load's new value appears on bcd_out at the following edge (1-cycle latency).
  - Back-to-back strobes each take effect in order.
- Prescaler:
  - div_cnt counts 0..SCAN_DIV-1.
  - At an edge where div_cnt==SCAN_DIV-1: div_cnt<=0, idx<=(idx==DIGITS-1)?0:idx+1, and scan_tick<=1. At all other edges scan_tick<=0.
  - Scan period is exactly SCAN_DIV cycles per digit and DIGITS*SCAN_DIV cycles per frame.
- Output register: updated every edge from the current (pre-edge) idx and shadow. Output therefore lags idx by 1 cycle, and scan_tick is coincident with the first cycle of the new idx value.
  - bcd_out <= shadow nibble[idx].
  - digit_sel <= all ones, except bit idx = 0, when disp_en=1 and digit idx is not blanked.
  - Otherwise digit_sel <= all ones; bcd_out still carries the nibble.
- Blanking:
  - Digit k (k>=1) is blanked when blank_lead=1 and nibbles k..DIGITS-1 are all zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Blanking is evaluated from shadow each cycle, so a load that changes the leading digits re-blanks them immediately.
- Simultaneous events: a load and a scan advance in the same cycle are independent and both take effect. disp_en and blank_lead take effect on the next edge.
- No other state machine exists; idx is never out of range (wrap at DIGITS-1).

Test Plan (DIGITS=4, SCAN_DIV=4):
- Reset release, no load, disp_en=1, blank_lead=0:
  - digit_sel sequence is 1110,1101,1011,0111, repeating, with each value held 4 cycles and bcd_out=0.
  - scan_tick pulses every 4 cycles.
- Load din=16'h1234 (din_vld one cycle) -> one cycle later, during digit 0 dwell, bcd_out=4; it then follows 3,2,1 aligned with digit_sel 1101,1011,0111. err stays 0.
- Load 16'h0012 then 16'h00A5:
  - First load is accepted.
  - Second load pulses err=1 for one cycle, and the shadow keeps 0012.
- blank_lead=1 with shadow=16'h0007:
  - Only digit 0 is ever driven (1110); digits 1-3 give digit_sel=1111.
  - With shadow=0, digit 0 shows bcd_out=0.
- disp_en=0 mid-frame: digit_sel=1111 from the next edge while scan_tick keeps its 4-cycle period. Restoring disp_en resumes at the current idx, with no phase slip.
- Assert sys_rst_n=0 asynchronously during a dwell: outputs immediately return to reset values and shadow=0. After release, scanning restarts at digit 0 with a full 4-cycle dwell.
